// File: rtl/util_fifo_stepdown.sv
// Width-decreasing synchronous FIFO: one wide word in, INPUT_SCALE narrow words out,
// lowest lane first. Storage is a ring of narrow slots with first-word-fall-through output.
module util_fifo_stepdown #(
  parameter int OUTPUT_WIDTH = 32,
  parameter int INPUT_SCALE  = 2,
  parameter int DEPTH        = 128
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [OUTPUT_WIDTH*INPUT_SCALE-1:0]   din,
  input  logic                                  wren,
  input  logic                                  rden,
  output logic [OUTPUT_WIDTH-1:0]               dout,
  output logic [$clog2(DEPTH*INPUT_SCALE):0]    dcnt,
  output logic                                  full,
  output logic                                  empty
);

  localparam int PHYSICAL_DEPTH = DEPTH * INPUT_SCALE;
  localparam int INPUT_WIDTH    = OUTPUT_WIDTH * INPUT_SCALE;
  localparam int AW             = $clog2(PHYSICAL_DEPTH);

  localparam logic [AW:0] FULL_THRESH = (AW+1)'(PHYSICAL_DEPTH - INPUT_SCALE);
  localparam logic [AW:0] WR_STEP     = (AW+1)'(INPUT_SCALE);

  logic [OUTPUT_WIDTH-1:0] r_mem [PHYSICAL_DEPTH];
  logic [AW:0]             r_wcnt;
  logic [AW:0]             r_rcnt;

  logic [AW-1:0]           w_wptr;
  logic [AW-1:0]           w_rptr;
  logic [AW:0]             w_dcnt;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_wr_acc;
  logic                    w_rd_acc;

  assign w_wptr   = r_wcnt[AW-1:0];
  assign w_rptr   = r_rcnt[AW-1:0];
  assign w_dcnt   = r_wcnt - r_rcnt;
  assign w_full   = (w_dcnt > FULL_THRESH);
  assign w_empty  = (w_dcnt == '0);
  assign w_wr_acc = wren & ~w_full;
  assign w_rd_acc = rden & ~w_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wcnt <= '0;
      r_rcnt <= '0;
    end else begin
      if (w_wr_acc) r_wcnt <= r_wcnt + WR_STEP;
      if (w_rd_acc) r_rcnt <= r_rcnt + 1'b1;
    end
  end

  // Write pointer is always lane-aligned, so w_wptr+i never crosses the ring wrap.
  always_ff @(posedge clk) begin
    if (rst_n && w_wr_acc) begin
      for (int i = 0; i < INPUT_SCALE; i++) begin
        r_mem[w_wptr + AW'(i)] <= din[i*OUTPUT_WIDTH +: OUTPUT_WIDTH];
      end
    end
  end

  assign dout  = r_mem[w_rptr];
  assign dcnt  = w_dcnt;
  assign full  = w_full;
  assign empty = w_empty;

endmodule

// File: tb/tb_util_fifo_stepdown.sv
// Directed self-checking bench for util_fifo_stepdown (OUTPUT_WIDTH=8, INPUT_SCALE=2, DEPTH=4).
module tb_util_fifo_stepdown;

  logic        clk;
  logic        rst_n;
  logic [15:0] din;
  logic        wren;
  logic        rden;
  logic [7:0]  dout;
  logic [3:0]  dcnt;
  logic        full;
  logic        empty;

  int checks;
  int errors;

  util_fifo_stepdown #(.OUTPUT_WIDTH(8), .INPUT_SCALE(2), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (din),
    .wren  (wren),
    .rden  (rden),
    .dout  (dout),
    .dcnt  (dcnt),
    .full  (full),
    .empty (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [15:0] d);
    din = d; wren = 1'b1; rden = 1'b0;
    step();
    wren = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [7:0] exp_head);
    chk(tag, dout, exp_head);
    rden = 1'b1; wren = 1'b0;
    step();
    rden = 1'b0;
  endtask

  logic [7:0] q[$];
  int wi;
  int ri;
  int cyc;
  logic do_wr;
  logic do_rd;

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; wren = 1'b1; rden = 1'b1; din = 16'hFFEE;

    // reset held two cycles with wren/rden active
    step(); step();
    chk("rst_dcnt", dcnt, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    rst_n = 1'b1; wren = 1'b0; rden = 1'b0;
    step();
    chk("post_rst_dcnt", dcnt, 0);

    // ordering
    wr(16'hBBAA);
    chk("ord_dcnt2", dcnt, 2);
    chk("ord_empty0", empty, 0);
    rd("ord_aa", 8'hAA);
    chk("ord_dcnt1", dcnt, 1);
    rd("ord_bb", 8'hBB);
    chk("ord_empty", empty, 1);
    chk("ord_dcnt0", dcnt, 0);
    rden = 1'b1; step(); rden = 1'b0;
    chk("ord_underflow", dcnt, 0);

    // full boundary
    wr(16'h1100); wr(16'h3322); wr(16'h5544); wr(16'h7766);
    chk("full_dcnt8", dcnt, 8);
    chk("full_flag", full, 1);
    wr(16'h9988);
    chk("full_drop_dcnt", dcnt, 8);
    rd("full_h00", 8'h00);
    chk("full_dcnt7", dcnt, 7);
    chk("full_still", full, 1);
    rd("full_h11", 8'h11);
    chk("full_dcnt6", dcnt, 6);
    chk("full_clear", full, 0);
    rd("full_h22", 8'h22);
    rd("full_h33", 8'h33);
    rd("full_h44", 8'h44);
    rd("full_h55", 8'h55);
    rd("full_h66", 8'h66);
    rd("full_h77", 8'h77);
    chk("full_no88", empty, 1);

    // simultaneous at dcnt=0: write only
    din = 16'h0201; wren = 1'b1; rden = 1'b1; step(); wren = 1'b0; rden = 1'b0;
    chk("sim0_dcnt", dcnt, 2);
    rd("sim0_h01", 8'h01);
    chk("sim1_pre", dcnt, 1);
    // simultaneous at dcnt=1: both
    din = 16'h0403; wren = 1'b1; rden = 1'b1; step(); wren = 1'b0; rden = 1'b0;
    chk("sim1_dcnt", dcnt, 2);
    wr(16'h0605); wr(16'h0807);
    rd("sim_h03", 8'h03);
    wr(16'h0A09);
    chk("sim7_dcnt", dcnt, 7);
    chk("sim7_full", full, 1);
    // simultaneous at dcnt=7 (full): read only
    din = 16'h0C0B; wren = 1'b1; rden = 1'b1; step(); wren = 1'b0; rden = 1'b0;
    chk("sim7_after", dcnt, 6);
    rd("sim_h05", 8'h05);
    rd("sim_h06", 8'h06);
    rd("sim_h07", 8'h07);
    rd("sim_h08", 8'h08);
    rd("sim_h09", 8'h09);
    rd("sim_h0a", 8'h0A);
    chk("sim_drained", empty, 1);

    // wrap and stream with random stalls, scoreboard queue
    wi = 0; ri = 0; cyc = 0;
    while (ri < 80 && cyc < 2000) begin
      do_wr = (wi < 40) && ($urandom_range(0, 3) != 0);
      do_rd = ($urandom_range(0, 2) != 0);
      wren = do_wr;
      rden = do_rd;
      din = {8'(2*wi + 1), 8'(2*wi)};
      chk("strm_dcnt", dcnt, q.size());
      if (do_rd && !empty) begin
        if (q.size() == 0) chk("strm_spurious", 1, 0);
        else chk("strm_dout", dout, q.pop_front());
        ri++;
      end
      if (do_wr && !full) begin
        q.push_back(8'(2*wi));
        q.push_back(8'(2*wi + 1));
        wi++;
      end
      step();
      cyc++;
    end
    wren = 1'b0; rden = 1'b0;
    chk("strm_done", ri, 80);
    chk("strm_empty", empty, 1);

    // mid-stream reset
    wr(16'h2211); wr(16'h4433); wr(16'h6655);
    rd("mr_h11", 8'h11);
    chk("mr_dcnt5", dcnt, 5);
    rst_n = 1'b0; wren = 1'b1; rden = 1'b1; din = 16'hEEEE;
    step();
    rst_n = 1'b1; wren = 1'b0; rden = 1'b0;
    chk("mr_dcnt0", dcnt, 0);
    chk("mr_empty", empty, 1);
    wr(16'hDDCC);
    chk("mr_dcnt2", dcnt, 2);
    rd("mr_hcc", 8'hCC);
    rd("mr_hdd", 8'hDD);
    chk("mr_end_empty", empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
